// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers BCD digits and the overflow lamp from a scanned 7-segment display.
// Ports: clk/rst (sync, active-high); seg_in {a..g}, seg_ovf, dig_sel (one-hot) from the display;
//        out_valid/out_ready handshake with out_bcd, out_err, out_ovf; frame_drop pulses on a lost frame.
// Latency: 1 cycle from the capture edge of the last digit to out_valid. Collection never stalls;
//          a frame completing while the output slot is held is dropped.
// Optional: define SEG7_ACTIVE_LOW_EN for common-anode boards (all inputs inverted at the input register).
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic                    seg_ovf,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_ovf,
  output logic                    frame_drop
);

  // Counter runs one past the capture value and sticks there, so each dwell captures once.
  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES + 1);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

  // ---------------- input polarity + register ----------------
  logic [6:0]            seg_pol;
  logic                  ovf_pol;
  logic [NUM_DIGITS-1:0] sel_pol;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_pol = ~seg_in;
  assign ovf_pol = ~seg_ovf;
  assign sel_pol = ~dig_sel;
`else
  assign seg_pol = seg_in;
  assign ovf_pol = seg_ovf;
  assign sel_pol = dig_sel;
`endif

  logic [6:0]            seg_r, seg_p;
  logic [NUM_DIGITS-1:0] sel_r, sel_p;
  logic                  ovf_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= '0;
      sel_r <= '0;
      ovf_r <= 1'b0;
      seg_p <= '0;
      sel_p <= '0;
    end else begin
      seg_r <= seg_pol;
      sel_r <= sel_pol;
      ovf_r <= ovf_pol;
      seg_p <= seg_r;
      sel_p <= sel_r;
    end
  end

  // ---------------- stability counter ----------------
  logic          onehot, same;
  logic [CW-1:0] cnt;

  assign onehot = ($countones(sel_r) == 1);
  assign same   = (seg_r == seg_p) && (sel_r == sel_p);

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (!onehot)     cnt <= '0;
    else if (!same)       cnt <= CW'(1);
    else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
  end

  // cnt describes the sample now held in seg_p/sel_p, so that is what gets captured.
  logic                  cap;
  logic [NUM_DIGITS-1:0] cap_vec;

  assign cap     = (cnt == CNT_CAP);
  assign cap_vec = cap ? sel_p : '0;

  // ---------------- decoder (exact match only) ----------------
  logic [3:0] dec_nib;
  logic       dec_err;

  always_comb begin
    dec_nib = 4'hF;
    dec_err = 1'b0;
    case (seg_p)
      7'b1111110: dec_nib = 4'd0;
      7'b0110000: dec_nib = 4'd1;
      7'b1101101: dec_nib = 4'd2;
      7'b1111001: dec_nib = 4'd3;
      7'b0110011: dec_nib = 4'd4;
      7'b1011011: dec_nib = 4'd5;
      7'b1011111: dec_nib = 4'd6;
      7'b1110000: dec_nib = 4'd7;
      7'b1111111: dec_nib = 4'd8;
      7'b1111011: dec_nib = 4'd9;
      default: begin
        dec_nib = 4'hF;
        dec_err = 1'b1;
      end
    endcase
  end

  // ---------------- partial frame ----------------
  logic [NUM_DIGITS-1:0]   flags, new_flags;
  logic [4*NUM_DIGITS-1:0] part_bcd, frm_bcd;
  logic [NUM_DIGITS-1:0]   part_err, frm_err;
  logic                    part_ovf, frm_ovf;
  logic                    complete, slot_free, load, drop;

  assign new_flags = flags | cap_vec;
  assign complete  = cap && (&new_flags);
  assign slot_free = !out_valid || out_ready;
  assign load      = complete && slot_free;
  assign drop      = complete && !slot_free;

  // Frame as it stands after this edge's capture, so the last digit loads straight to the output.
  always_comb begin
    frm_bcd = part_bcd;
    frm_err = part_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_vec[i]) begin
        frm_bcd[4*i +: 4] = dec_nib;
        frm_err[i]        = dec_err;
      end
    end
    frm_ovf = part_ovf | ovf_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= '0;
      part_bcd <= '0;
      part_err <= '0;
      part_ovf <= 1'b0;
    end else begin
      part_bcd <= frm_bcd;
      part_err <= frm_err;
      if (complete) begin
        flags    <= '0;
        part_ovf <= 1'b0;
      end else begin
        flags <= new_flags;
        if (cap) part_ovf <= frm_ovf;
      end
    end
  end

  // ---------------- output slot FSM ----------------
  slot_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= SLOT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (load)           state_d = SLOT_FULL;
        else if (out_ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == SLOT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_bcd    <= '0;
      out_err    <= '0;
      out_ovf    <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= drop;
      if (load) begin
        out_bcd <= frm_bcd;
        out_err <= frm_err;
        out_ovf <= frm_ovf;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed bench for seg7_scan_decoder with NUM_DIGITS=2, STABLE_CYCLES=4.
// Drives scanned digit dwells and checks recovered frames, backpressure drop, overflow and reset.
// Inputs change #1 after a rising edge; outputs are read #1 after an edge or on the falling edge.
module tb_seg7_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       seg_ovf;
  logic [1:0] dig_sel;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_bcd;
  logic [1:0] out_err;
  logic       out_ovf;
  logic       frame_drop;

  int n_chk  = 0;
  int n_pass = 0;
  int n_xfer = 0;
  int n_drop = 0;
  logic [7:0] last_bcd = 8'h00;
  int base_x, base_d;

  logic [6:0] pat [10];

  seg7_scan_decoder #(.NUM_DIGITS(2), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_ovf    (seg_ovf),
    .dig_sel    (dig_sel),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_bcd    (out_bcd),
    .out_err    (out_err),
    .out_ovf    (out_ovf),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_xfer++;
        last_bcd = out_bcd;
      end
      if (frame_drop) n_drop++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Hold one digit pattern across n rising edges.
  task automatic show(input logic [1:0] sel, input logic [6:0] seg, input logic ovf, input int n);
    dig_sel = sel;
    seg_in  = seg;
    seg_ovf = ovf;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
    pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
    pat[8] = 7'b1111111; pat[9] = 7'b1111011;

    rst = 1'b1; seg_in = 7'h00; seg_ovf = 1'b0; dig_sel = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_bcd",   32'(out_bcd),   32'h0);
    check("rst_err",   32'(out_err),   32'h0);
    check("rst_ovf",   32'(out_ovf),   32'h0);
    check("rst_drop",  32'(frame_drop), 32'h0);
    rst = 1'b0;

    // Basic frame 43, ready high: valid one cycle after the last capture edge, for one cycle.
    base_x = n_xfer;
    show(2'b01, pat[3], 1'b0, 5);
    show(2'b10, pat[4], 1'b0, 5);
    show(2'b00, 7'h00, 1'b0, 1);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_bcd",   32'(out_bcd),   32'h43);
    check("basic_err",   32'(out_err),   32'h0);
    check("basic_ovf",   32'(out_ovf),   32'h0);
    show(2'b00, 7'h00, 1'b0, 1);
    check("basic_fall",  32'(out_valid), 32'h0);
    check("basic_xfers", 32'(n_xfer - base_x), 32'h1);

    // Glitch: 3 cycles of '0' is too short, the following '8' dwell wins; the 00 gap captures nothing.
    show(2'b01, pat[0], 1'b0, 3);
    show(2'b01, pat[8], 1'b0, 4);
    show(2'b00, 7'h00, 1'b0, 3);
    show(2'b10, pat[1], 1'b0, 5);
    show(2'b00, 7'h00, 1'b0, 1);
    check("glitch_valid", 32'(out_valid), 32'h1);
    check("glitch_bcd",   32'(out_bcd),   32'h18);
    check("glitch_err",   32'(out_err),   32'h0);
    show(2'b00, 7'h00, 1'b0, 2);

    // Blank digit 0 is unrecognised.
    show(2'b01, 7'b0000000, 1'b0, 5);
    show(2'b10, pat[1], 1'b0, 5);
    show(2'b00, 7'h00, 1'b0, 1);
    check("inv_valid", 32'(out_valid), 32'h1);
    check("inv_bcd",   32'(out_bcd),   32'h1F);
    check("inv_err",   32'(out_err),   32'h1);
    show(2'b00, 7'h00, 1'b0, 2);

    // Backpressure: frame 12 held, frame 34 dropped, then 12 transfers.
    out_ready = 1'b0;
    base_x = n_xfer;
    base_d = n_drop;
    show(2'b01, pat[2], 1'b0, 5);
    show(2'b10, pat[1], 1'b0, 5);
    show(2'b00, 7'h00, 1'b0, 1);
    check("bp_valid1", 32'(out_valid), 32'h1);
    check("bp_bcd1",   32'(out_bcd),   32'h12);
    show(2'b01, pat[4], 1'b0, 5);
    show(2'b10, pat[3], 1'b0, 5);
    check("bp_hold_mid", 32'(out_bcd), 32'h12);
    check("bp_nodrop_yet", 32'(n_drop - base_d), 32'h0);
    show(2'b00, 7'h00, 1'b0, 1);
    check("bp_drop_pulse", 32'(frame_drop), 32'h1);
    check("bp_hold_bcd",   32'(out_bcd),    32'h12);
    check("bp_hold_valid", 32'(out_valid),  32'h1);
    out_ready = 1'b1;
    show(2'b00, 7'h00, 1'b0, 1);
    check("bp_drop_end", 32'(frame_drop), 32'h0);
    check("bp_fall",     32'(out_valid),  32'h0);
    check("bp_xfer_bcd", 32'(last_bcd),   32'h12);
    check("bp_xfers",    32'(n_xfer - base_x), 32'h1);
    check("bp_drops",    32'(n_drop - base_d), 32'h1);
    show(2'b00, 7'h00, 1'b0, 2);

    // Overflow lamp during digit 1 only, then a clean frame.
    show(2'b01, pat[5], 1'b0, 5);
    show(2'b10, pat[6], 1'b1, 5);
    show(2'b00, 7'h00, 1'b0, 1);
    check("ovf_bcd1", 32'(out_bcd), 32'h65);
    check("ovf_set",  32'(out_ovf), 32'h1);
    show(2'b00, 7'h00, 1'b0, 2);
    show(2'b01, pat[7], 1'b0, 5);
    show(2'b10, pat[9], 1'b0, 5);
    show(2'b00, 7'h00, 1'b0, 1);
    check("ovf_bcd2",  32'(out_bcd), 32'h97);
    check("ovf_clear", 32'(out_ovf), 32'h0);
    show(2'b00, 7'h00, 1'b0, 2);

    // Reset mid-frame: digit 0 lost, digit 1 alone never completes.
    base_x = n_xfer;
    base_d = n_drop;
    show(2'b01, pat[8], 1'b0, 5);
    show(2'b00, 7'h00, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    show(2'b10, pat[2], 1'b0, 5);
    show(2'b00, 7'h00, 1'b0, 4);
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_bcd",   32'(out_bcd),   32'h0);
    check("mrst_err",   32'(out_err),   32'h0);
    check("mrst_ovf",   32'(out_ovf),   32'h0);
    check("mrst_xfers", 32'(n_xfer - base_x), 32'h0);
    check("mrst_drops", 32'(n_drop - base_d), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
